// File: rtl/siganfu_target_tracker.sv
// siganfu_target_tracker: radar lock qualifier and IFF handshake for the siganfu gun controller.
// Produces target_locked / is_enemy from consecutive radar hits and the IFF responder answer.
// Optional range gate: define TRACKER_RANGE_GATE_EN to count only hits with radar_range <= MAX_RANGE;
// when undefined every radar_hit counts and radar_range is ignored.
module siganfu_target_tracker #(
  parameter int LOCK_HITS   = 4,
  parameter int MISS_LIMIT  = 3,
  parameter int IFF_TIMEOUT = 8,
  parameter int MAX_RANGE   = 200,
  parameter int CNT_W       = 4
) (
  input  logic       sysclk,
  input  logic       reboot_n,
  input  logic       radar_hit,
  input  logic [7:0] radar_range,
  input  logic       iff_ack,
  input  logic       iff_friend,
  output logic       iff_req,
  output logic       target_locked,
  output logic       is_enemy,
  output logic [1:0] track_state
);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;
  localparam logic [1:0] ST_COAST   = 2'd3;

  // Terminal counter values: reaching these on a qualifying event ends the count.
  localparam logic [CNT_W-1:0] HIT_LAST  = CNT_W'(LOCK_HITS - 1);
  localparam logic [CNT_W-1:0] MISS_LAST = CNT_W'(MISS_LIMIT - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(IFF_TIMEOUT - 1);

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] hit_cnt_reg, hit_cnt_next;
  logic [CNT_W-1:0] miss_cnt_reg, miss_cnt_next;
  logic [CNT_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic             retry_reg, retry_next;   // query timed out; re-assert iff_req next edge
  logic             iff_req_next, is_enemy_next;
  logic             lock_start;              // fresh lock (not a COAST re-entry): open a new query
  logic             qhit;

`ifdef TRACKER_RANGE_GATE_EN
  assign qhit = radar_hit & (radar_range <= 8'(MAX_RANGE));
`else
  logic unused_range;
  assign unused_range = ^radar_range;
  assign qhit = radar_hit;
`endif

  // Outputs derived directly from registers; LOCKED and COAST share state bit 1.
  assign track_state   = state_reg;
  assign target_locked = state_reg[1];

  // Track state machine with hit/miss counting.
  always_comb begin
    state_next    = state_reg;
    hit_cnt_next  = hit_cnt_reg;
    miss_cnt_next = miss_cnt_reg;
    lock_start    = 1'b0;
    case (state_reg)
      ST_SEARCH: begin
        if (qhit) begin
          if (LOCK_HITS == 1) begin
            state_next   = ST_LOCKED;
            hit_cnt_next = '0;
            lock_start   = 1'b1;
          end else begin
            state_next   = ST_ACQUIRE;
            hit_cnt_next = CNT_W'(1);
          end
        end
      end
      ST_ACQUIRE: begin
        if (!qhit) begin
          state_next   = ST_SEARCH;
          hit_cnt_next = '0;
        end else if (hit_cnt_reg >= HIT_LAST) begin
          state_next    = ST_LOCKED;
          hit_cnt_next  = '0;
          miss_cnt_next = '0;
          lock_start    = 1'b1;
        end else begin
          hit_cnt_next = hit_cnt_reg + 1'b1;
        end
      end
      ST_LOCKED: begin
        if (qhit) begin
          miss_cnt_next = '0;
        end else if (MISS_LIMIT == 1) begin
          state_next    = ST_SEARCH;
          miss_cnt_next = '0;
        end else begin
          state_next    = ST_COAST;
          miss_cnt_next = CNT_W'(1);
        end
      end
      default: begin  // ST_COAST
        if (qhit) begin
          state_next    = ST_LOCKED;
          miss_cnt_next = '0;
        end else if (miss_cnt_reg >= MISS_LAST) begin
          state_next    = ST_SEARCH;
          miss_cnt_next = '0;
        end else begin
          miss_cnt_next = miss_cnt_reg + 1'b1;
        end
      end
    endcase
  end

  // IFF query: open on a fresh lock, close on ack, pulse low for one cycle on timeout.
  always_comb begin
    iff_req_next  = iff_req;
    is_enemy_next = is_enemy;
    tmo_cnt_next  = tmo_cnt_reg;
    retry_next    = retry_reg;
    if (!state_next[1]) begin
      // Not locked after this edge: drop everything, including a coincident answer.
      iff_req_next  = 1'b0;
      is_enemy_next = 1'b0;
      tmo_cnt_next  = '0;
      retry_next    = 1'b0;
    end else if (lock_start) begin
      iff_req_next  = 1'b1;
      is_enemy_next = 1'b0;
      tmo_cnt_next  = '0;
      retry_next    = 1'b0;
    end else if (iff_req) begin
      if (iff_ack) begin
        iff_req_next  = 1'b0;
        is_enemy_next = ~iff_friend;
        tmo_cnt_next  = '0;
      end else if (tmo_cnt_reg >= TMO_LAST) begin
        iff_req_next = 1'b0;
        tmo_cnt_next = '0;
        retry_next   = 1'b1;
      end else begin
        tmo_cnt_next = tmo_cnt_reg + 1'b1;
      end
    end else if (retry_reg) begin
      iff_req_next = 1'b1;
      tmo_cnt_next = '0;
      retry_next   = 1'b0;
    end
  end

  // State register bank; reset clears lock and any pending query at once.
  always_ff @(posedge sysclk or negedge reboot_n) begin
    if (!reboot_n) begin
      state_reg    <= ST_SEARCH;
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
      tmo_cnt_reg  <= '0;
      retry_reg    <= 1'b0;
      iff_req      <= 1'b0;
      is_enemy     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hit_cnt_reg  <= hit_cnt_next;
      miss_cnt_reg <= miss_cnt_next;
      tmo_cnt_reg  <= tmo_cnt_next;
      retry_reg    <= retry_next;
      iff_req      <= iff_req_next;
      is_enemy     <= is_enemy_next;
    end
  end

endmodule

// File: tb/tb_siganfu_target_tracker.sv
// Directed bench for siganfu_target_tracker with hand-computed expectations.
`timescale 1ns/1ps
module tb_siganfu_target_tracker;

  logic       sysclk;
  logic       reboot_n;
  logic       radar_hit;
  logic [7:0] radar_range;
  logic       iff_ack;
  logic       iff_friend;
  logic       iff_req;
  logic       target_locked;
  logic       is_enemy;
  logic [1:0] track_state;

  int n_total = 0;
  int n_bad   = 0;

  siganfu_target_tracker dut (
    .sysclk        (sysclk),
    .reboot_n      (reboot_n),
    .radar_hit     (radar_hit),
    .radar_range   (radar_range),
    .iff_ack       (iff_ack),
    .iff_friend    (iff_friend),
    .iff_req       (iff_req),
    .target_locked (target_locked),
    .is_enemy      (is_enemy),
    .track_state   (track_state)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 ns after the rising edge.
  task automatic cyc(input logic hit, input logic [7:0] rng, input logic ack, input logic frd);
    radar_hit   = hit;
    radar_range = rng;
    iff_ack     = ack;
    iff_friend  = frd;
    @(posedge sysclk);
    #1;
  endtask

  task automatic hit100();  cyc(1'b1, 8'd100, 1'b0, 1'b0); endtask
  task automatic miss();    cyc(1'b0, 8'd0,   1'b0, 1'b0); endtask

  initial begin
    reboot_n = 1'b0;
    radar_hit = 1'b0; radar_range = '0; iff_ack = 1'b0; iff_friend = 1'b0;
    #12;
    chk("rst_state",  track_state,   0);
    chk("rst_locked", target_locked, 0);
    chk("rst_req",    iff_req,       0);
    chk("rst_enemy",  is_enemy,      0);
    @(posedge sysclk); #2;
    reboot_n = 1'b1;

    // 1: four hits -> 1,1,1,2
    hit100(); chk("t1_s1", track_state, 1);
    hit100(); chk("t1_s2", track_state, 1);
    hit100(); chk("t1_s3", track_state, 1); chk("t1_nolock3", target_locked, 0);
    hit100(); chk("t1_s4", track_state, 2);
    chk("t1_locked", target_locked, 1); chk("t1_req", iff_req, 1); chk("t1_enemy", is_enemy, 0);

    // 3: hostile answer
    cyc(1'b1, 8'd100, 1'b1, 1'b0);
    chk("t3_req_clr", iff_req, 0); chk("t3_enemy", is_enemy, 1);

    // 5: 2 misses then hit keeps enemy, then 3 misses drop
    miss(); chk("t5_coast1", track_state, 3); chk("t5_locked_coast", target_locked, 1);
    miss(); chk("t5_coast2", track_state, 3);
    hit100(); chk("t5_relock", track_state, 2); chk("t5_enemy_kept", is_enemy, 1);
    chk("t5_no_requery", iff_req, 0);
    miss(); miss(); chk("t5_coast_m2", track_state, 3);
    miss(); chk("t5_drop", track_state, 0); chk("t5_drop_locked", target_locked, 0);
    chk("t5_drop_enemy", is_enemy, 0);

    // 2: 3 hits, miss, 4 hits
    hit100(); hit100(); hit100(); chk("t2_acq", track_state, 1);
    miss(); chk("t2_back_search", track_state, 0);
    hit100(); hit100(); hit100(); chk("t2_nolock3", target_locked, 0);
    hit100(); chk("t2_lock", track_state, 2); chk("t2_req", iff_req, 1);

    // 4: no ack for 8 cycles -> 1-cycle gap in iff_req
    for (int i = 1; i <= 7; i++) begin
      hit100(); chk($sformatf("t4_req_hi%0d", i), iff_req, 1);
    end
    hit100(); chk("t4_req_gap", iff_req, 0); chk("t4_enemy_gap", is_enemy, 0);
    hit100(); chk("t4_req_again", iff_req, 1);

    // 3b: friendly answer, then a stray hostile ack with no query is ignored
    cyc(1'b1, 8'd100, 1'b1, 1'b1);
    chk("t3b_req_clr", iff_req, 0); chk("t3b_enemy", is_enemy, 0);
    cyc(1'b1, 8'd100, 1'b1, 1'b0);
    chk("t3b_stray_ack", is_enemy, 0); chk("t3b_stray_req", iff_req, 0);

    // drop, re-lock, then hostile ack coincides with the dropping miss
    miss(); miss(); miss(); chk("sim_search", track_state, 0);
    hit100(); hit100(); hit100(); hit100(); chk("sim_lock", track_state, 2);
    miss(); miss(); chk("sim_coast", track_state, 3); chk("sim_req_open", iff_req, 1);
    cyc(1'b0, 8'd0, 1'b1, 1'b0);
    chk("sim_drop_state", track_state, 0); chk("sim_drop_enemy", is_enemy, 0);
    chk("sim_drop_req", iff_req, 0);

    // 6: range gate boundary
`ifdef TRACKER_RANGE_GATE_EN
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 8'd201, 1'b0, 1'b0); chk($sformatf("t6_r201_%0d", i), track_state, 0);
    end
`else
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 8'd201, 1'b0, 1'b0);
      chk($sformatf("t6_r201_%0d", i), track_state, (i == 3) ? 2 : 1);
    end
    miss(); miss(); miss(); chk("t6_ungated_drop", track_state, 0);
`endif
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'd200, 1'b0, 1'b0);
    chk("t6_r200_lock", track_state, 2);
    miss(); chk("t6_coast", track_state, 3);

    // asynchronous reset mid-COAST, checked before the next clock edge
    #3 reboot_n = 1'b0;
    #1;
    chk("t6_arst_state",  track_state,   0);
    chk("t6_arst_locked", target_locked, 0);
    chk("t6_arst_req",    iff_req,       0);
    chk("t6_arst_enemy",  is_enemy,      0);
    #20 reboot_n = 1'b1;
    @(posedge sysclk); #1;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
